// File: rtl/mem_transfer_ctrl.sv
// Purpose: scans memory A words 0..3 and packs every word above a captured threshold into memory B from address 0.
// Latency: a pass takes 13 cycles after the accepted start (RD/CMP/WR per word, then a one-cycle done pulse).
// Backpressure: none; start is only sampled in IDLE and ignored while busy, threshold is frozen for the pass.
module mem_transfer_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] thresh,
    input  logic [7:0] DOutA,
    output logic [1:0] AddrA,
    output logic [1:0] AddrB,
    output logic       WEB,
    output logic [7:0] DataInB,
    output logic       busy,
    output logic       done,
    output logic [2:0] count
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CMP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t     state;
    state_t     stateNext;
    logic [7:0] thrQ;
    logic [1:0] rdPtr;
    logic [1:0] wrPtr;

    // Read address follows the scan pointer; memory A returns data one cycle later (in CMP).
    assign AddrA = rdPtr;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic: four RD/CMP/WR rounds, then a single DONE cycle.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    stateNext = start ? RD : IDLE;
            RD:      stateNext = CMP;
            CMP:     stateNext = WR;
            WR:      stateNext = (rdPtr == 2'd3) ? DONE : RD;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Datapath: threshold capture, compare/stage the write, commit pointers at the end of WR.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            thrQ    <= 8'd0;
            rdPtr   <= 2'd0;
            wrPtr   <= 2'd0;
            count   <= 3'd0;
            WEB     <= 1'b0;
            AddrB   <= 2'd0;
            DataInB <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        thrQ  <= thresh;
                        rdPtr <= 2'd0;
                        wrPtr <= 2'd0;
                        count <= 3'd0;
                    end
                end
                CMP: begin
                    // Strictly greater, unsigned; address/data only move when a write is staged.
                    if (DOutA > thrQ) begin
                        DataInB <= DOutA;
                        AddrB   <= wrPtr;
                        WEB     <= 1'b1;
                    end else begin
                        WEB <= 1'b0;
                    end
                end
                WR: begin
                    // Memory B captures on this edge; WEB is high for the WR cycle only.
                    WEB <= 1'b0;
                    if (WEB) begin
                        wrPtr <= wrPtr + 2'd1;
                        count <= count + 3'd1;
                    end
                    if (rdPtr != 2'd3) begin
                        rdPtr <= rdPtr + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
